regfile_uart_ctrl: RTL and testbench
====================================

Name: regfile_uart_ctrl

Overview:
- Command sequencer between the on-chip UART RX/TX pair and the configuration regfile.
- Unloads each received 18-bit packet, checks its parity and address, and performs the regfile write or read.
- For reads (and optionally writes), builds a response packet and hands it to the UART TX for return on piso.
- Keeps saturating error counters that the digital_core testbus can observe.

Parameters:
- NUMREGS, 32, number of implemented regfile addresses; valid addresses are 0..NUMREGS-1.
- ECHO_WRITES, 1, when 1 every accepted write is echoed back as a response packet.
- TX_ACK_TIMEOUT, 64, cycles to wait for tx_busy to rise after ld_tx_data before abandoning the response.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  18  packet from uart_rx: [17] parity, [16:9] addr, [8:1] data, [0] wrb.
- rx_empty  in  1  low when uart_rx holds an unread packet.
- uld_rx_data  out  1  one-cycle unload strobe to uart_rx.
- tx_busy  in  1  high while uart_tx is shifting.
- ld_tx_data  out  1  one-cycle load strobe to uart_tx.
- tx_data  out  18  response packet, same field layout as rx_data.
- reg_addr  out  8  regfile address.
- reg_wdata  out  8  regfile write data.
- reg_we  out  1  one-cycle regfile write enable.
- reg_rdata  in  8  regfile read data, registered, valid 1 cycle after reg_addr.
- parity_err_cnt  out  8  saturating count of rejected parity errors.
- addr_err_cnt  out  8  saturating count of rejected out-of-range addresses.
- tx_timeout_cnt  out  8  saturating count of TX ack timeouts.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs are 0 and the FSM enters IDLE. A reset mid-packet or mid-transmit abandons the operation; reg_we is guaranteed low on the cycle after reset.
- Packet parity is odd: a packet is good when ^rx_data[17:0] == 1. Generated responses set bit17 = ~^bits[16:0].
- wrb = 0 means write; wrb = 1 means read.
- IDLE: when rx_empty = 0, go to UNLOAD. uld_rx_data is high for exactly that one cycle.
- UNLOAD -> CAPTURE: rx_data is registered into pkt.
- CAPTURE -> DECODE, with checks in this order:
  - parity bad: parity_err_cnt++, no regfile access, no response, go to IDLE.
  - addr >= NUMREGS: addr_err_cnt++, go to IDLE.
  - wrb = 0: go to WRITE.
  - wrb = 1: go to READ.
- If parity and address are both bad, only parity_err_cnt increments.
- WRITE: reg_addr = addr, reg_wdata = data, reg_we = 1 for exactly one cycle. Then go to TX_WAIT if ECHO_WRITES, else IDLE. The echo payload is {parity, addr, data, 1'b0}.
- READ: drive reg_addr, then READ_WAIT for one cycle, then latch reg_rdata. The response payload is {parity, addr, reg_rdata, 1'b1}. Go to TX_WAIT.
- Write latency: reg_we is asserted 4 cycles after the first clk edge that sees rx_empty low.
- TX_WAIT: hold until tx_busy = 0, then go to TX_LOAD. ld_tx_data = 1 for one cycle, with tx_data stable from TX_LOAD until the FSM returns to IDLE.
- TX_ACK: wait for tx_busy = 1, then go to IDLE. If TX_ACK_TIMEOUT cycles elapse without tx_busy, tx_timeout_cnt++ and go to IDLE.
- Packets arriving during a transaction stay in uart_rx; none is unloaded until IDLE. Overrun is uart_rx's responsibility.
- All counters saturate at 8'hFF and never wrap.
- busy = (state != IDLE).

Decomposition:
- Shared package psd_uart_pkg holds:
  - field index constants: PAR_BIT = 17, ADDR_MSB = 16, ADDR_LSB = 9, DATA_MSB = 8, DATA_LSB = 1, WRB_BIT = 0;
  - typedef uart_pkt_t, a packed struct with parity, addr, data, wrb;
  - the state enum ctrl_state_t;
  - a function odd_parity().
- One sub-module, sat_counter8 (increment-enable, synchronous clear, saturate), instantiated three times. All other logic is inline.

Test Plan:
- Good write {par, 8'h05, 8'hAB, 0} -> reg_we pulse with reg_addr = 05 and reg_wdata = AB; echo tx_data = {par, 05, AB, 0} with odd parity; one ld_tx_data pulse.
- Read of addr 8'h05 after that write, with the regfile model returning AB -> tx_data = {par, 05, AB, 1}; reg_we never asserts.
- Bad-parity write to 8'h03 -> no reg_we, no ld_tx_data, parity_err_cnt = 1. Address 8'h20 with good parity -> addr_err_cnt = 1, no access.
- tx_busy held high for 500 cycles with a read pending -> FSM waits in TX_WAIT and issues no ld_tx_data. Then tx_busy tied low -> exactly one load, TX_ACK timeout after 64 cycles, tx_timeout_cnt = 1.
- 300 bad-parity packets -> parity_err_cnt stops at FF. reset = 1 for one cycle -> all counters 0, busy = 0.
- Reset asserted while in READ_WAIT -> no ld_tx_data ever issued for that packet; the next good packet is processed normally.

Source files
------------

// File: rtl/psd_uart_pkg.sv
// Shared packet layout, FSM state encoding and parity helpers for the
// UART-to-regfile command path.
package psd_uart_pkg;

    localparam int PAR_BIT  = 17;
    localparam int ADDR_MSB = 16;
    localparam int ADDR_LSB = 9;
    localparam int DATA_MSB = 8;
    localparam int DATA_LSB = 1;
    localparam int WRB_BIT  = 0;

    typedef struct packed {
        logic       parity;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wrb;
    } uart_pkt_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_UNLOAD,
        ST_CAPTURE,
        ST_DECODE,
        ST_WRITE,
        ST_READ,
        ST_READ_WAIT,
        ST_TX_WAIT,
        ST_TX_LOAD,
        ST_TX_ACK
    } ctrl_state_t;

    // Parity bit that makes the whole 18-bit packet carry an odd number of ones.
    function automatic logic odd_parity(input logic [16:0] bits);
        return ~^bits;
    endfunction

    function automatic uart_pkt_t build_pkt(input logic [7:0] addr,
                                            input logic [7:0] data,
                                            input logic       wrb);
        uart_pkt_t p;
        p.addr   = addr;
        p.data   = data;
        p.wrb    = wrb;
        p.parity = odd_parity({addr, data, wrb});
        return p;
    endfunction

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 8'hFF instead of wrapping.
module sat_counter8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/regfile_uart_ctrl.sv
// Command sequencer: unloads UART packets, validates them, performs the
// regfile access and returns read data (and write echoes) through uart_tx.
//
// state        | meaning
// IDLE         | waiting for uart_rx to hold a packet
// UNLOAD       | unload strobe to uart_rx, packet captured at end of cycle
// CAPTURE      | parity and address range evaluated
// DECODE       | reject (count error) or dispatch to WRITE / READ
// WRITE        | one-cycle regfile write enable
// READ         | address presented to the regfile
// READ_WAIT    | registered read data returns, response built
// TX_WAIT      | waiting for uart_tx to go idle
// TX_LOAD      | one-cycle load strobe to uart_tx
// TX_ACK       | waiting for uart_tx to report busy, bounded by a timer
module regfile_uart_ctrl
    import psd_uart_pkg::*;
#(
    parameter int NUMREGS        = 32,
    parameter int ECHO_WRITES    = 1,
    parameter int TX_ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] rx_data,
    input  logic        rx_empty,
    output logic        uld_rx_data,
    input  logic        tx_busy,
    output logic        ld_tx_data,
    output logic [17:0] tx_data,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    input  logic [7:0]  reg_rdata,
    output logic [7:0]  parity_err_cnt,
    output logic [7:0]  addr_err_cnt,
    output logic [7:0]  tx_timeout_cnt,
    output logic        busy
);

    localparam int TW = $clog2(TX_ACK_TIMEOUT + 1);

    ctrl_state_t state, state_nxt;
    uart_pkt_t   pkt, tx_pkt;
    logic        par_ok, addr_ok;
    logic [TW-1:0] ack_timer;
    logic        inc_par, inc_addr, inc_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pkt       <= '0;
            tx_pkt    <= '0;
            par_ok    <= 1'b0;
            addr_ok   <= 1'b0;
            ack_timer <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_UNLOAD: begin
                    pkt.parity <= rx_data[PAR_BIT];
                    pkt.addr   <= rx_data[ADDR_MSB:ADDR_LSB];
                    pkt.data   <= rx_data[DATA_MSB:DATA_LSB];
                    pkt.wrb    <= rx_data[WRB_BIT];
                end
                ST_CAPTURE: begin
                    par_ok  <= (pkt.parity == odd_parity(pkt[16:0]));
                    addr_ok <= (32'(pkt.addr) < NUMREGS);
                end
                ST_WRITE:     tx_pkt <= build_pkt(pkt.addr, pkt.data, 1'b0);
                ST_READ_WAIT: tx_pkt <= build_pkt(pkt.addr, reg_rdata, 1'b1);
                // Timer spans exactly TX_ACK_TIMEOUT cycles of TX_ACK.
                ST_TX_LOAD:   ack_timer <= TW'(TX_ACK_TIMEOUT - 1);
                ST_TX_ACK: begin
                    if (ack_timer != '0) begin
                        ack_timer <= ack_timer - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        uld_rx_data = 1'b0;
        ld_tx_data  = 1'b0;
        reg_we      = 1'b0;
        inc_par     = 1'b0;
        inc_addr    = 1'b0;
        inc_tmo     = 1'b0;
        case (state)
            ST_IDLE:      if (!rx_empty) state_nxt = ST_UNLOAD;
            ST_UNLOAD: begin
                uld_rx_data = 1'b1;
                state_nxt   = ST_CAPTURE;
            end
            ST_CAPTURE:   state_nxt = ST_DECODE;
            ST_DECODE: begin
                // Parity is judged first, so a doubly bad packet only counts once.
                if (!par_ok) begin
                    inc_par   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!addr_ok) begin
                    inc_addr  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (pkt.wrb) begin
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                reg_we    = 1'b1;
                state_nxt = (ECHO_WRITES != 0) ? ST_TX_WAIT : ST_IDLE;
            end
            ST_READ:      state_nxt = ST_READ_WAIT;
            ST_READ_WAIT: state_nxt = ST_TX_WAIT;
            ST_TX_WAIT:   if (!tx_busy) state_nxt = ST_TX_LOAD;
            ST_TX_LOAD: begin
                ld_tx_data = 1'b1;
                state_nxt  = ST_TX_ACK;
            end
            ST_TX_ACK: begin
                if (tx_busy) begin
                    state_nxt = ST_IDLE;
                end else if (ack_timer == '0) begin
                    inc_tmo   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default:      state_nxt = ST_IDLE;
        endcase
    end

    assign reg_addr  = pkt.addr;
    assign reg_wdata = pkt.data;
    assign tx_data   = tx_pkt;
    assign busy      = (state != ST_IDLE);

    sat_counter8 u_par_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (inc_par),
        .count (parity_err_cnt)
    );

    sat_counter8 u_addr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (inc_addr),
        .count (addr_err_cnt)
    );

    sat_counter8 u_tmo_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (inc_tmo),
        .count (tx_timeout_cnt)
    );

endmodule

// File: tb/tb_regfile_uart_ctrl.sv
// Directed bench for regfile_uart_ctrl with a small regfile model and
// hand-computed packet values.
module tb_regfile_uart_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] rx_data;
    logic        rx_empty;
    logic        uld_rx_data;
    logic        tx_busy;
    logic        ld_tx_data;
    logic [17:0] tx_data;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic [7:0]  reg_rdata;
    logic [7:0]  parity_err_cnt;
    logic [7:0]  addr_err_cnt;
    logic [7:0]  tx_timeout_cnt;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] mem [32] = '{default: 8'h00};
    int         ld_cnt = 0;
    int         we_cnt = 0;
    logic [7:0] we_addr = 8'h00;
    logic [7:0] we_data = 8'h00;
    logic [17:0] ld_val;

    regfile_uart_ctrl #(
        .NUMREGS        (32),
        .ECHO_WRITES    (1),
        .TX_ACK_TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .uld_rx_data    (uld_rx_data),
        .tx_busy        (tx_busy),
        .ld_tx_data     (ld_tx_data),
        .tx_data        (tx_data),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_we         (reg_we),
        .reg_rdata      (reg_rdata),
        .parity_err_cnt (parity_err_cnt),
        .addr_err_cnt   (addr_err_cnt),
        .tx_timeout_cnt (tx_timeout_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Regfile model: registered read, one cycle after address.
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr[4:0]] <= reg_wdata;
        reg_rdata <= mem[reg_addr[4:0]];
    end

    always @(posedge clk) begin
        if (ld_tx_data) ld_cnt <= ld_cnt + 1;
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [17:0] p);
        bit seen = 0;
        @(negedge clk);
        rx_data  = p;
        rx_empty = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (uld_rx_data) seen = 1;
        end
        rx_empty = 1'b1;
        chk("uld_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_ld(input bit ack);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ld_tx_data) begin
                seen   = 1;
                ld_val = tx_data;
                if (ack) tx_busy = 1'b1;
            end
        end
        chk("ld_seen", 32'(seen), 32'd1);
    endtask

    task automatic tx_round(input string tag, input logic [17:0] exp_tx);
        wait_ld(1'b1);
        chk(tag, 32'(ld_val), 32'(exp_tx));
        wait_idle();
        tx_busy = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = '0;
        rx_empty = 1'b1;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_tx",     32'(tx_data), 32'h0);
        chk("rst_ctl",    32'({uld_rx_data, ld_tx_data, reg_we}), 32'd0);
        chk("rst_cnts",   32'({parity_err_cnt, addr_err_cnt, tx_timeout_cnt}), 32'd0);
        reset = 1'b0;

        // Good write 05 <- AB, checks 4-cycle latency, then echo.
        send(18'h00B56);
        repeat (3) @(negedge clk);
        chk("wr_we",    32'(reg_we), 32'd1);
        chk("wr_addr",  32'(reg_addr), 32'h05);
        chk("wr_data",  32'(reg_wdata), 32'hAB);
        @(negedge clk);
        chk("wr_we_one_cycle", 32'(reg_we), 32'd0);
        tx_round("wr_echo", 18'h00B56);
        chk("wr_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("wr_we_cnt", 32'(we_cnt), 32'd1);

        // Read 05 returns AB.
        send(18'h00A01);
        tx_round("rd_resp", 18'h20B57);
        chk("rd_no_we",  32'(we_cnt), 32'd1);
        chk("rd_ld_cnt", 32'(ld_cnt), 32'd2);

        // Bad-parity write to 03.
        send(18'h00622);
        wait_idle();
        chk("par_cnt1",   32'(parity_err_cnt), 32'd1);
        chk("par_no_we",  32'(we_cnt), 32'd1);
        chk("par_no_ld",  32'(ld_cnt), 32'd2);

        // Address 20, good parity.
        send(18'h04000);
        wait_idle();
        chk("addr_cnt1",  32'(addr_err_cnt), 32'd1);
        chk("addr_par",   32'(parity_err_cnt), 32'd1);
        chk("addr_no_we", 32'(we_cnt), 32'd1);
        chk("addr_no_ld", 32'(ld_cnt), 32'd2);

        // Address 20 with bad parity: only parity counts.
        send(18'h24000);
        wait_idle();
        chk("both_par",  32'(parity_err_cnt), 32'd2);
        chk("both_addr", 32'(addr_err_cnt), 32'd1);

        // Highest valid address 1F <- 5A.
        send(18'h03EB4);
        tx_round("wr1f_echo", 18'h03EB4);
        chk("wr1f_we_cnt", 32'(we_cnt), 32'd2);
        chk("wr1f_addr",   32'(we_addr), 32'h1F);
        chk("wr1f_data",   32'(we_data), 32'h5A);
        chk("wr1f_addr_cnt", 32'(addr_err_cnt), 32'd1);

        // Read 1F with uart_tx busy for 500 cycles, then an ack timeout.
        tx_busy = 1'b1;
        send(18'h23E01);
        repeat (500) @(negedge clk);
        chk("hold_no_ld", 32'(ld_cnt), 32'd3);
        chk("hold_busy",  32'(busy), 32'd1);
        tx_busy = 1'b0;
        wait_ld(1'b0);
        chk("tmo_resp", 32'(ld_val), 32'h23EB5);
        repeat (64) @(negedge clk);
        chk("tmo_still_busy", 32'(busy), 32'd1);
        chk("tmo_cnt_early",  32'(tx_timeout_cnt), 32'd0);
        @(negedge clk);
        chk("tmo_idle",    32'(busy), 32'd0);
        chk("tmo_cnt",     32'(tx_timeout_cnt), 32'd1);
        chk("tmo_ld_once", 32'(ld_cnt), 32'd4);

        // Reset while in READ_WAIT abandons the read.
        send(18'h00A01);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rrst_busy", 32'(busy), 32'd0);
        chk("rrst_tx",   32'(tx_data), 32'h0);
        chk("rrst_cnts", 32'({parity_err_cnt, addr_err_cnt, tx_timeout_cnt}), 32'd0);
        repeat (20) @(negedge clk);
        chk("rrst_no_ld", 32'(ld_cnt), 32'd4);
        send(18'h20A78);
        tx_round("rrst_next_echo", 18'h20A78);
        chk("rrst_next_we",   32'(we_cnt), 32'd3);
        chk("rrst_next_data", 32'(we_data), 32'h3C);

        // Saturation of the parity error counter.
        for (int i = 0; i < 255; i++) begin
            send(18'h00622);
            wait_idle();
        end
        chk("sat_255", 32'(parity_err_cnt), 32'hFF);
        for (int i = 0; i < 45; i++) begin
            send(18'h00622);
            wait_idle();
        end
        chk("sat_300", 32'(parity_err_cnt), 32'hFF);
        chk("sat_no_we", 32'(we_cnt), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("final_rst_cnts", 32'({parity_err_cnt, addr_err_cnt, tx_timeout_cnt}), 32'd0);
        chk("final_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no end expected finish");
        $fatal(1, "watchdog");
    end

endmodule
